ahb_reset_sequencer: RTL
========================

Name: ahb_reset_sequencer

Overview:
- Generates staged, per-domain active-low bus resets for the AHB bus matrix system.
- Reset sources: the power-on reset, a software reset request and a watchdog reset request.
- Holds every domain in reset for a minimum stretch, then releases the domains one at a time in index order. Typical order is domain 0 = bus matrix/interconnect, then slaves, then masters.
- Records the cause of the last reset in a sticky status register.

Parameters:
- NUM_DOMAINS, 3, number of reset domains (1..8).
- STRETCH_CYCLES, 16, minimum HCLK cycles all domains are held in reset after the last reset source goes inactive (>=1).
- STAGE_GAP, 4, HCLK cycles between releases of consecutive domains (>=1).

Ports:
- HCLK  in  1  system clock.
- POReset  in  1  power-on reset. Asynchronous, active-high.
- SYSRESETREQ  in  1  software reset request. Level, active-high, synchronous to HCLK.
- WDOGRESREQ  in  1  watchdog reset request. Level, active-high, synchronous to HCLK.
- RSTCAUSE_CLR  in  1  one-cycle pulse that clears RSTCAUSE.
- HRESETn  out  NUM_DOMAINS  per-domain resets, active-low, registered.
- RESET_DONE  out  1  high when all domains are released.
- RSTCAUSE  out  3  sticky cause flags: bit0 = power-on, bit1 = software, bit2 = watchdog.

Behaviour:
- Interface decision: one clock, HCLK. Reset POReset is asynchronous and active-high.
- All outputs are registered. No combinational path from any input to any output.

POReset (asynchronous, takes effect immediately, no clock needed):
- HRESETn = all 0, RESET_DONE = 0, RSTCAUSE = 3'b001.
- State = ASSERT, cnt = 0, stage = 0.

Request sampling:
- req = SYSRESETREQ | WDOGRESREQ, sampled on each HCLK rising edge.

State ASSERT (all HRESETn = 0, RESET_DONE = 0):
- If req: cnt = 0, stay in ASSERT. Holding req keeps the stretch from starting.
- Else if cnt == STRETCH_CYCLES-1:
  - HRESETn[0] = 1, cnt = 0.
  - If NUM_DOMAINS == 1: go to RUN and set RESET_DONE = 1 on the same edge.
  - Otherwise: go to RELEASE with stage = 1.
- Else: cnt++.

State RELEASE:
- If req: go to ASSERT; HRESETn = all 0 and cnt = 0 on the same edge.
- Else if cnt == STAGE_GAP-1:
  - HRESETn[stage] = 1, cnt = 0.
  - If stage == NUM_DOMAINS-1: go to RUN and set RESET_DONE = 1 on the same edge.
  - Otherwise: stage++.
- Else: cnt++.

State RUN (all HRESETn = 1, RESET_DONE = 1):
- If req: go to ASSERT; HRESETn = all 0, RESET_DONE = 0, cnt = 0 on the same edge.

Resulting timing:
- Domain k is released at edge STRETCH_CYCLES + k*STAGE_GAP, counted from the first edge after POReset deasserts or after req is last sampled high.
- Released domains never re-enter reset except through ASSERT, and re-entry always asserts all domains together.

RSTCAUSE updates at each edge:
- bit1 is set when SYSRESETREQ is sampled high.
- bit2 is set when WDOGRESREQ is sampled high.
- RSTCAUSE_CLR clears all bits, but a set from the same edge wins over the clear.
- Software and watchdog resets never clear existing bits. Only POReset forces RSTCAUSE = 001.
- Simultaneous SYSRESETREQ and WDOGRESREQ set both bits and cause a single restart.

Counter width:
- Sized for max(STRETCH_CYCLES, STAGE_GAP).
- stage width is clog2(NUM_DOMAINS), minimum 1.

Test Plan:
1. POR release (defaults): POReset 1 then 0. Result: HRESETn = 000 until edge 15; 001 at edge 16; 011 at edge 20; 111 at edge 24. RESET_DONE rises at edge 24. RSTCAUSE = 001.
2. Software reset in RUN: 1-cycle SYSRESETREQ sampled at edge E. Result: HRESETn = 000 and RESET_DONE = 0 at E. RSTCAUSE = 011. Domains released at E+16, E+20, E+24.
3. Held watchdog request during RELEASE (after 001, before 011): WDOGRESREQ held high 10 cycles. Result: HRESETn = 000 on the first sampling edge and stays 000 while the request is held. Domain 0 is released 16 edges after the last high sample. RSTCAUSE bit2 = 1.
4. Cause clear: RSTCAUSE_CLR pulse alone gives RSTCAUSE = 000. RSTCAUSE_CLR on the same edge as WDOGRESREQ gives RSTCAUSE = 100 plus a restart.
5. Asynchronous POR mid-sequence: assert POReset between clock edges while HRESETn = 011. Result: HRESETn = 000 and RSTCAUSE = 001 immediately, before the next edge. A full 16/20/24 sequence follows deassertion.
6. Parameter corner: NUM_DOMAINS = 1, STRETCH_CYCLES = 1, STAGE_GAP = 1. Result: HRESETn = 1 and RESET_DONE = 1 at the first edge after POReset falls. A simultaneous SYSRESETREQ and WDOGRESREQ pulse gives RSTCAUSE = 111 and a single restart.

Source files
------------

// File: rtl/ahb_reset_sequencer.sv
// AHB bus matrix reset sequencer.
// Holds every domain in reset for a stretch after the last reset source goes
// away, then releases the domains one at a time in index order. The cause of
// the last reset is kept in a sticky register.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_ASSERT   | all domains in reset, stretch timer running while no request
// ST_RELEASE  | domains below stage_q released, gap timer running
// ST_RUN      | all domains released, waiting for the next reset request
module ahb_reset_sequencer #(
  parameter int NUM_DOMAINS    = 3,
  parameter int STRETCH_CYCLES = 16,
  parameter int STAGE_GAP      = 4
) (
  input  logic                   HCLK,
  input  logic                   POReset,
  input  logic                   SYSRESETREQ,
  input  logic                   WDOGRESREQ,
  input  logic                   RSTCAUSE_CLR,
  output logic [NUM_DOMAINS-1:0] HRESETn,
  output logic                   RESET_DONE,
  output logic [2:0]             RSTCAUSE
);

  localparam int CNT_MAX = (STRETCH_CYCLES > STAGE_GAP) ? STRETCH_CYCLES : STAGE_GAP;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int SW      = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  // Timers count down to zero, so the load value is the interval minus one.
  localparam logic [CW-1:0] STRETCH_LOAD = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD     = CW'(STAGE_GAP - 1);
  localparam logic [SW-1:0] LAST_STAGE   = SW'(NUM_DOMAINS - 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SW-1:0]          stage_q, stage_d;
  logic [NUM_DOMAINS-1:0] hresetn_q, hresetn_d;
  logic                   done_q, done_d;
  logic [2:0]             cause_q, cause_d;

  logic req;
  logic tc;
  logic last_stage;

  assign req        = SYSRESETREQ | WDOGRESREQ;
  assign tc         = (cnt_q == '0);
  assign last_stage = (stage_q == LAST_STAGE);

  // State, timer, stage and registered outputs; POReset forces the full reset image.
  always_ff @(posedge HCLK or posedge POReset) begin
    if (POReset) begin
      state_q   <= ST_ASSERT;
      cnt_q     <= STRETCH_LOAD;
      stage_q   <= '0;
      hresetn_q <= '0;
      done_q    <= 1'b0;
      cause_q   <= 3'b001;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stage_q   <= stage_d;
      hresetn_q <= hresetn_d;
      done_q    <= done_d;
      cause_q   <= cause_d;
    end
  end

  // Next state, timer reload/decrement and release stage pointer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    case (state_q)
      ST_ASSERT: begin
        if (req) begin
          cnt_d = STRETCH_LOAD;
        end else if (tc) begin
          cnt_d = GAP_LOAD;
          if (NUM_DOMAINS == 1) begin
            state_d = ST_RUN;
            stage_d = '0;
          end else begin
            state_d = ST_RELEASE;
            stage_d = SW'(1);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RELEASE: begin
        if (req) begin
          state_d = ST_ASSERT;
          cnt_d   = STRETCH_LOAD;
          stage_d = '0;
        end else if (tc) begin
          cnt_d = GAP_LOAD;
          if (last_stage) begin
            state_d = ST_RUN;
          end else begin
            stage_d = stage_q + SW'(1);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RUN: begin
        if (req) begin
          state_d = ST_ASSERT;
          cnt_d   = STRETCH_LOAD;
          stage_d = '0;
        end
      end
      default: begin
        state_d = ST_ASSERT;
        cnt_d   = STRETCH_LOAD;
        stage_d = '0;
      end
    endcase
  end

  // Domain resets, done flag and sticky cause; a set on the same edge beats a clear.
  always_comb begin
    hresetn_d = hresetn_q;
    done_d    = done_q;
    cause_d   = RSTCAUSE_CLR ? 3'b000 : cause_q;
    cause_d   = cause_d | {WDOGRESREQ, SYSRESETREQ, 1'b0};
    case (state_q)
      ST_ASSERT: begin
        hresetn_d = '0;
        done_d    = 1'b0;
        if (!req && tc) begin
          hresetn_d[0] = 1'b1;
          done_d       = (NUM_DOMAINS == 1);
        end
      end
      ST_RELEASE: begin
        if (req) begin
          hresetn_d = '0;
          done_d    = 1'b0;
        end else if (tc) begin
          hresetn_d[stage_q] = 1'b1;
          done_d             = last_stage;
        end
      end
      ST_RUN: begin
        if (req) begin
          hresetn_d = '0;
          done_d    = 1'b0;
        end
      end
      default: begin
        hresetn_d = '0;
        done_d    = 1'b0;
      end
    endcase
  end

  assign HRESETn    = hresetn_q;
  assign RESET_DONE = done_q;
  assign RSTCAUSE   = cause_q;

endmodule
